// File: rtl/sram_like_arbiter.sv
// Merges instruction fetch and data load/store onto one sram-like bus and raises a single pipeline stall.
// Build option ARB_INST_FIRST_EN: fetch wins when both channels are pending (default: data wins).
//
// state | meaning
// IDLE  | no bus transaction outstanding; arbitrate pending channels
// REQ   | mem_req asserted, waiting for mem_addr_ok
// WAIT  | address accepted, waiting for mem_data_ok
module sram_like_arbiter #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [BE_W-1:0]   data_be,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_nxt;
  logic              sel_data, sel_data_nxt;
  logic              inst_done, inst_done_nxt;
  logic              data_done, data_done_nxt;
  logic              mem_req_nxt, mem_wr_nxt;
  logic [BE_W-1:0]   mem_be_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] inst_rdata_nxt, data_rdata_nxt;
  logic              inst_pend, data_pend, pick_data;

  assign inst_pend = inst_req & ~inst_done;
  assign data_pend = data_req & ~data_done;
  // Only registered done flags feed the stall, so no mem_* input reaches it combinationally.
  assign cpu_stall = inst_pend | data_pend;

`ifdef ARB_INST_FIRST_EN
  assign pick_data = data_pend & ~inst_pend;
`else
  assign pick_data = data_pend;
`endif

  always_comb begin
    state_nxt      = state;
    sel_data_nxt   = sel_data;
    inst_done_nxt  = inst_done;
    data_done_nxt  = data_done;
    mem_req_nxt    = mem_req;
    mem_wr_nxt     = mem_wr;
    mem_be_nxt     = mem_be;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    inst_rdata_nxt = inst_rdata;
    data_rdata_nxt = data_rdata;

    case (state)
      IDLE: begin
        if (inst_pend | data_pend) begin
          state_nxt    = REQ;
          mem_req_nxt  = 1'b1;
          sel_data_nxt = pick_data;
          if (pick_data) begin
            mem_wr_nxt    = data_wr;
            mem_be_nxt    = data_wr ? data_be : '0;
            mem_addr_nxt  = data_addr;
            mem_wdata_nxt = data_wdata;
          end else begin
            mem_wr_nxt    = 1'b0;
            mem_be_nxt    = '0;
            mem_addr_nxt  = inst_addr;
            mem_wdata_nxt = '0;
          end
        end
      end
      REQ: begin
        if (mem_addr_ok) begin
          mem_req_nxt = 1'b0;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          state_nxt = IDLE;
          if (sel_data) begin
            if (!mem_wr) data_rdata_nxt = mem_rdata;
            data_done_nxt = 1'b1;
          end else begin
            inst_rdata_nxt = mem_rdata;
            inst_done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Pipeline advance releases both channels for the next instruction.
    if (!cpu_stall) begin
      inst_done_nxt = 1'b0;
      data_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_data   <= 1'b0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      state      <= state_nxt;
      sel_data   <= sel_data_nxt;
      inst_done  <= inst_done_nxt;
      data_done  <= data_done_nxt;
      mem_req    <= mem_req_nxt;
      mem_wr     <= mem_wr_nxt;
      mem_be     <= mem_be_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      inst_rdata <= inst_rdata_nxt;
      data_rdata <= data_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed reset/fetch/reset-in-WAIT cases, then random instruction groups
// against a transaction-order and cycle-count model with a randomly stalling bus.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_inst;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  txn_t exp_q[$];
  txn_t cur;
  int   bphase = 0;
  int   bcnt   = 0;
  int   exp_cycles;
  logic [31:0] exp_inst = 32'h0;
  logic [31:0] exp_data = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Bus responder, called once per negedge: random addr/data wait states plus stray handshakes that must be ignored.
  task automatic bus_step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    case (bphase)
      0: begin
        if (mem_req) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_issue", 32'(mem_req), 32'h0);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
            check_eq("issue_addr", mem_addr, cur.addr);
            check_eq("issue_wr", 32'(mem_wr), 32'(cur.wr));
            check_eq("issue_be", 32'(mem_be), 32'(cur.be));
            if (cur.is_inst || cur.wr) check_eq("issue_wdata", mem_wdata, cur.wdata);
          end
          bcnt = $urandom_range(0, 3);
          exp_cycles += 3 + bcnt;
          if (bcnt == 0) begin
            mem_addr_ok = 1'b1;
            bphase = 2;
            bcnt = $urandom_range(0, 3);
            exp_cycles += bcnt;
          end else begin
            bcnt--;
            bphase = 1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          mem_data_ok = 1'b1;
          mem_addr_ok = 1'($urandom_range(0, 1));
          mem_rdata   = $urandom;
        end
      end
      1: begin
        check_eq("req_held", 32'(mem_req), 32'h1);
        check_eq("req_addr_stable", mem_addr, cur.addr);
        check_eq("req_be_stable", 32'(mem_be), 32'(cur.be));
        check_eq("req_wr_stable", 32'(mem_wr), 32'(cur.wr));
        if (cur.wr) check_eq("req_wdata_stable", mem_wdata, cur.wdata);
        if (bcnt == 0) begin
          mem_addr_ok = 1'b1;
          bphase = 2;
          bcnt = $urandom_range(0, 3);
          exp_cycles += bcnt;
        end else begin
          bcnt--;
          mem_data_ok = 1'($urandom_range(0, 1));
          mem_rdata   = $urandom;
        end
      end
      default: begin
        check_eq("wait_req_low", 32'(mem_req), 32'h0);
        if (bcnt == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata   = $urandom;
          if (cur.is_inst) exp_inst = mem_rdata;
          else if (!cur.wr) exp_data = mem_rdata;
          bphase = 0;
        end else begin
          bcnt--;
        end
      end
    endcase
  endtask

  initial begin
    logic [31:0] first_addr, second_addr;
    txn_t t_inst, t_data;
    int stall_cnt;
    bit abort = 0;

    rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    data_req = 1'b0; data_wr = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // Reset held two cycles with a fetch pending, then a zero-wait fetch.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_req", 32'(mem_req), 32'h0);
    check_eq("rst_stall", 32'(cpu_stall), 32'h1);
    check_eq("rst_inst_rdata", inst_rdata, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("f0_stall", 32'(cpu_stall), 32'h1);
    check_eq("f0_mem_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    check_eq("f1_mem_req", 32'(mem_req), 32'h1);
    check_eq("f1_mem_addr", mem_addr, 32'hBFC0_0000);
    check_eq("f1_stall", 32'(cpu_stall), 32'h1);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    check_eq("f2_mem_req", 32'(mem_req), 32'h0);
    check_eq("f2_stall", 32'(cpu_stall), 32'h1);
    mem_data_ok = 1'b1; mem_rdata = 32'h3C08_8000;
    @(negedge clk);
    mem_data_ok = 1'b0;
    check_eq("f3_stall", 32'(cpu_stall), 32'h0);
    check_eq("f3_inst_rdata", inst_rdata, 32'h3C08_8000);

    // Simultaneous load and fetch, then reset while the second one is in WAIT.
`ifdef ARB_INST_FIRST_EN
    first_addr = 32'hBFC0_0004; second_addr = 32'h8000_1000;
`else
    first_addr = 32'h8000_1000; second_addr = 32'hBFC0_0004;
`endif
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000; inst_addr = 32'hBFC0_0004;
    @(posedge clk);
    @(negedge clk);
    check_eq("s_first_req", 32'(mem_req), 32'h1);
    check_eq("s_first_addr", mem_addr, first_addr);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_data_ok = 1'b0;
    check_eq("s_mid_stall", 32'(cpu_stall), 32'h1);
    @(negedge clk);
    check_eq("s_second_addr", mem_addr, second_addr);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("wrst_mem_req", 32'(mem_req), 32'h0);
    check_eq("wrst_inst_rdata", inst_rdata, 32'h0);
    check_eq("wrst_data_rdata", data_rdata, 32'h0);
    check_eq("wrst_stall", 32'(cpu_stall), 32'h1);
    @(negedge clk);
    check_eq("wrst_reissue_req", 32'(mem_req), 32'h1);
    check_eq("wrst_reissue_addr", mem_addr, first_addr);
    rst = 1'b1;
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_data_ok = 1'b1; mem_addr_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    check_eq("idle_ok_inst_rdata", inst_rdata, 32'h0);
    check_eq("idle_ok_data_rdata", data_rdata, 32'h0);
    check_eq("idle_ok_mem_req", 32'(mem_req), 32'h0);
    check_eq("idle_ok_stall", 32'(cpu_stall), 32'h0);

    // Random instruction groups: the datapath holds its requests while stalled.
    for (int g = 0; g < 250 && !abort; g++) begin
      @(posedge clk); #1;
      inst_req   = ($urandom_range(0, 3) != 0);
      data_req   = 1'($urandom_range(0, 1));
      inst_addr  = $urandom & 32'hFFFF_FFFC;
      data_addr  = $urandom & 32'hFFFF_FFFC;
      data_wr    = 1'($urandom_range(0, 1));
      data_be    = 4'($urandom_range(1, 15));
      data_wdata = $urandom;
      t_inst = '{is_inst: 1'b1, wr: 1'b0, be: 4'h0, addr: inst_addr, wdata: 32'h0};
      t_data = '{is_inst: 1'b0, wr: data_wr, be: (data_wr ? data_be : 4'h0), addr: data_addr, wdata: data_wdata};
`ifdef ARB_INST_FIRST_EN
      if (inst_req) exp_q.push_back(t_inst);
      if (data_req) exp_q.push_back(t_data);
`else
      if (data_req) exp_q.push_back(t_data);
      if (inst_req) exp_q.push_back(t_inst);
`endif
      exp_cycles = 0;
      stall_cnt  = 0;
      forever begin
        @(negedge clk);
        bus_step();
        if (!cpu_stall) break;
        stall_cnt++;
        if (stall_cnt > 200) begin
          check_eq("stall_timeout", 32'(cpu_stall), 32'h0);
          abort = 1;
          break;
        end
      end
      if (!abort) begin
        check_eq("grp_stall_cycles", 32'(stall_cnt), 32'(exp_cycles));
        check_eq("grp_all_issued", 32'(exp_q.size()), 32'h0);
        check_eq("grp_inst_rdata", inst_rdata, exp_inst);
        check_eq("grp_data_rdata", data_rdata, exp_data);
        exp_q.delete();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
